// File: rtl/smc_pkg.sv
// Shared types, widths and helpers for the serial MOSFET-calculator controller.
// Holds the running top/bottom-3 insertion and the weighted frame result.
package smc_pkg;

   localparam int N_DEV = 6;
   localparam int VAL_W = 7;
   localparam int OUT_W = 10;

   localparam int MODE_ID  = 0;
   localparam int MODE_MAX = 1;

   localparam logic [OUT_W-1:0] WGT0 = OUT_W'(3);
   localparam logic [OUT_W-1:0] WGT1 = OUT_W'(4);
   localparam logic [OUT_W-1:0] WGT2 = OUT_W'(5);

   typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

   typedef logic [VAL_W-1:0] val_t;

   // Invariant k0 >= k1 >= k2.
   typedef struct packed {
      val_t k0;
      val_t k1;
      val_t k2;
   } sort_t;

   function automatic sort_t init_keys(input logic keep_max);
      sort_t r;
      r = keep_max ? '0 : '1;
      return r;
   endfunction

   // Strict compares so an equal newcomer never displaces an earlier device.
   function automatic sort_t sort_insert(input sort_t s, input val_t v, input logic keep_max);
      sort_t r;
      r = s;
      if (keep_max) begin
         if (v > s.k0) begin
            r.k0 = v;
            r.k1 = s.k0;
            r.k2 = s.k1;
         end else if (v > s.k1) begin
            r.k1 = v;
            r.k2 = s.k1;
         end else if (v > s.k2) begin
            r.k2 = v;
         end
      end else begin
         if (v < s.k2) begin
            r.k2 = v;
            r.k1 = s.k2;
            r.k0 = s.k1;
         end else if (v < s.k1) begin
            r.k1 = v;
            r.k0 = s.k1;
         end else if (v < s.k0) begin
            r.k0 = v;
         end
      end
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] frame_result(input sort_t s, input logic sel_id);
      logic [OUT_W-1:0] a, b, c;
      a = OUT_W'(s.k0);
      b = OUT_W'(s.k1);
      c = OUT_W'(s.k2);
      if (sel_id)
         return WGT0 * a + WGT1 * b + WGT2 * c;
      return a + b + c;
   endfunction

endpackage

// File: rtl/smc_seq_ctrl_if.sv
// Serial descriptor stream in, one-cycle frame result out.
// master drives descriptors and consumes results; slave is the controller.
interface smc_seq_ctrl_if;
   import smc_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [2:0]       w;
   logic [2:0]       v_gs;
   logic [2:0]       v_ds;
   logic             out_valid;
   logic [OUT_W-1:0] out_n;

   modport master (
      output in_valid, mode, w, v_gs, v_ds,
      input  in_ready, out_valid, out_n
   );

   modport slave (
      input  in_valid, mode, w, v_gs, v_ds,
      output in_ready, out_valid, out_n
   );

endinterface

// File: rtl/smc_dev_eval.sv
// Square-law device evaluation: drain current or transconductance of one transistor.
// Latency: purely combinational. Backpressure: none, no state.
// Region select: cutoff (v_gs<=1), triode (ov>v_ds), otherwise saturation.
module smc_dev_eval
   import smc_pkg::*;
(
   input  logic [2:0]       w,
   input  logic [2:0]       v_gs,
   input  logic [2:0]       v_ds,
   input  logic             sel_id,
   output logic [VAL_W-1:0] val
);

   logic [9:0] w_e, vds_e, ov_e;
   logic [9:0] id_num, gm_num, id_q, gm_q;
   logic       cutoff, triode;

   always_comb begin
      w_e    = {7'd0, w};
      vds_e  = {7'd0, v_ds};
      cutoff = (v_gs <= 3'd1);
      ov_e   = cutoff ? 10'd0 : {7'd0, v_gs - 3'd1};
      triode = !cutoff && (ov_e > vds_e);

      // Worst case numerator is 7*36 = 252, so 10 bits never wrap.
      if (triode) begin
         id_num = w_e * vds_e * ((ov_e << 1) - vds_e);
         gm_num = (w_e << 1) * vds_e;
      end else begin
         id_num = w_e * ov_e * ov_e;
         gm_num = (w_e << 1) * ov_e;
      end

      id_q = id_num / 10'd3;
      gm_q = gm_num / 10'd3;

      if (cutoff)
         val = '0;
      else
         val = sel_id ? VAL_W'(id_q) : VAL_W'(gm_q);
   end

endmodule

// File: rtl/smc_seq_ctrl.sv
// Serial six-device frame controller: evaluate, keep sorted top/bottom-3, emit weighted result.
// Latency: out_valid one cycle after the 6th accepted beat; 7 cycles minimum per frame.
// Backpressure: in_ready low only during the single OUT cycle; beats offered then are not taken.
module smc_seq_ctrl
   import smc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   smc_seq_ctrl_if.slave bus
);

   state_t           state;
   logic [2:0]       beat_cnt;
   logic [1:0]       mode_q;
   sort_t            keys;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [OUT_W-1:0] out_n_q;

   logic             accept;
   logic [1:0]       cur_mode;
   val_t             dev_val;
   sort_t            base_keys;
   sort_t            next_keys;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_n     = out_n_q;

   // The first beat of a frame arrives in IDLE and must see its own mode and fresh keys.
   always_comb begin
      accept    = bus.in_valid && in_ready_q;
      cur_mode  = (state == IDLE) ? bus.mode : mode_q;
      base_keys = (state == IDLE) ? init_keys(bus.mode[MODE_MAX]) : keys;
      next_keys = sort_insert(base_keys, dev_val, cur_mode[MODE_MAX]);
   end

   smc_dev_eval u_dev_eval (
      .w      (bus.w),
      .v_gs   (bus.v_gs),
      .v_ds   (bus.v_ds),
      .sel_id (cur_mode[MODE_ID]),
      .val    (dev_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         mode_q      <= '0;
         keys        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_n_q     <= '0;
      end else begin
         out_valid_q <= 1'b0;
         out_n_q     <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  mode_q   <= bus.mode;
                  keys     <= next_keys;
                  beat_cnt <= 3'd1;
                  state    <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  keys <= next_keys;
                  if (beat_cnt == 3'(N_DEV - 1)) begin
                     beat_cnt    <= '0;
                     state       <= OUT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_n_q     <= frame_result(next_keys, mode_q[MODE_ID]);
                  end else begin
                     beat_cnt <= beat_cnt + 3'd1;
                  end
               end
            end
            OUT: begin
               state      <= IDLE;
               in_ready_q <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Bench for smc_seq_ctrl: frame-level reference model checked every cycle plus literal results.
module tb_smc_seq_ctrl;
   import smc_pkg::*;

   typedef int arr6_t[6];
   typedef struct {
      int mode;
      int w;
      int vgs;
      int vds;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   smc_seq_ctrl_if bus ();

   smc_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic fail_timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
   endtask

   // Reference: value of one device straight from the square-law rules.
   function automatic int dev_value(input int w, input int vgs, input int vds, input bit want_id);
      int ov;
      if (vgs <= 1) return 0;
      ov = vgs - 1;
      if (ov > vds)
         return want_id ? (w * (2 * ov * vds - vds * vds)) / 3 : (2 * w * vds) / 3;
      return want_id ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
   endfunction

   // Reference: sort the whole frame, take the three extreme values, weight them.
   function automatic int frame_value(input beat_t f[$]);
      int  v[$];
      int  k0, k1, k2;
      bit  want_id, want_max;
      want_id  = (f[0].mode & 1) != 0;
      want_max = (f[0].mode & 2) != 0;
      foreach (f[i]) v.push_back(dev_value(f[i].w, f[i].vgs, f[i].vds, want_id));
      v.sort();
      if (want_max) begin
         k0 = v[N_DEV-1]; k1 = v[N_DEV-2]; k2 = v[N_DEV-3];
      end else begin
         k0 = v[2]; k1 = v[1]; k2 = v[0];
      end
      return want_id ? 3 * k0 + 4 * k1 + 5 * k2 : k0 + k1 + k2;
   endfunction

   // Model: beats are counted on edges where the source offers one and the
   // previous edge did not just complete a frame.
   beat_t fq[$];
   bit    out_cycle = 0;
   bit    exp_vld   = 0;
   int    exp_n     = 0;
   bit    started   = 0;
   int    cyc       = 0;

   always @(posedge clk) begin
      beat_t b;
      cyc++;
      exp_vld = 0;
      exp_n   = 0;
      if (rst) begin
         fq.delete();
         out_cycle = 0;
         started   = 1;
      end else if (out_cycle) begin
         out_cycle = 0;
      end else if (bus.in_valid === 1'b1) begin
         b.mode = int'(bus.mode);
         b.w    = int'(bus.w);
         b.vgs  = int'(bus.v_gs);
         b.vds  = int'(bus.v_ds);
         fq.push_back(b);
         if (fq.size() == N_DEV) begin
            exp_vld   = 1;
            exp_n     = frame_value(fq);
            out_cycle = 1;
            fq.delete();
         end
      end
   end

   int got_n[$];
   int got_cyc[$];

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready", 32'(bus.in_ready), 32'(!out_cycle));
         chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
         chk("out_n", 32'(bus.out_n), 32'(exp_n));
         if (bus.out_valid === 1'b1) begin
            got_n.push_back(int'(bus.out_n));
            got_cyc.push_back(cyc);
         end
      end
   end

   task automatic beat(input int m, input int wv, input int gv, input int dv, input int gap);
      bit r;
      repeat (gap) begin
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.mode     = 2'(m);
      bus.w        = 3'(wv);
      bus.v_gs     = 3'(gv);
      bus.v_ds     = 3'(dv);
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         r = bus.in_ready;
         @(posedge clk); #1;
         if (r) return;
      end
      fail_timeout("beat_accept");
   endtask

   task automatic send_frame(input arr6_t ms, input arr6_t ws, input arr6_t gs,
                             input arr6_t ds, input arr6_t gaps, input bit hold);
      for (int i = 0; i < N_DEV; i++) beat(ms[i], ws[i], gs[i], ds[i], gaps[i]);
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input int exp, output int c);
      c = -1;
      for (int t = 0; t < 40; t++) begin
         if (got_n.size() > 0) break;
         @(negedge clk); #1;
      end
      if (got_n.size() == 0) begin
         fail_timeout(name);
         return;
      end
      chk(name, 32'(got_n.pop_front()), 32'(exp));
      c = got_cyc.pop_front();
   endtask

   initial begin
      arr6_t ms, ws, gs, ds, g0, gr;
      int c1, c2;
      bus.in_valid = 1'b0;
      bus.mode = 2'd0; bus.w = 3'd0; bus.v_gs = 3'd0; bus.v_ds = 3'd0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_n", 32'(bus.out_n), 32'd0);
      @(posedge clk); #1;

      g0 = '{0, 0, 0, 0, 0, 0};
      gr = '{2, 0, 3, 1, 4, 2};

      ws = '{7, 7, 7, 7, 7, 7}; gs = ws; ds = ws;
      ms = '{3, 3, 3, 3, 3, 3};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("sat_id_max", 1008, c1);
      ms = '{2, 2, 2, 2, 2, 2};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("sat_gm_max", 84, c1);

      ws = '{3, 3, 3, 3, 3, 3}; gs = '{5, 2, 7, 3, 6, 4}; ds = '{7, 7, 7, 7, 7, 7};
      ms = '{3, 3, 3, 3, 3, 3};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("sweep_id_max", 288, c1);
      ms = '{1, 1, 1, 1, 1, 1};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("sweep_id_min", 48, c1);

      ms = '{3, 3, 3, 3, 3, 3};
      send_frame(ms, ws, gs, ds, gr, 0); expect_out("gaps_id_max", 288, c1);
      ms = '{3, 0, 1, 2, 0, 1};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("mode_latched", 288, c1);

      ws = '{3, 3, 3, 3, 3, 3}; gs = '{4, 0, 0, 0, 0, 0}; ds = '{2, 2, 2, 2, 2, 2};
      ms = '{3, 3, 3, 3, 3, 3};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("mix_id_max", 24, c1);
      ms = '{2, 2, 2, 2, 2, 2};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("mix_gm_max", 4, c1);
      ms = '{1, 1, 1, 1, 1, 1};
      send_frame(ms, ws, gs, ds, gr, 0); expect_out("mix_id_min", 0, c1);

      // Partial frame then reset; only the later frame may produce a result.
      beat(3, 7, 7, 7, 0);
      beat(3, 7, 7, 7, 1);
      beat(3, 7, 7, 7, 0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_no_out", 32'(got_n.size()), 32'd0);
      ws = '{7, 7, 7, 7, 7, 7}; gs = ws; ds = ws;
      ms = '{2, 2, 2, 2, 2, 2};
      send_frame(ms, ws, gs, ds, g0, 0); expect_out("after_rst", 84, c1);

      // Back-to-back with in_valid held through the OUT cycle.
      ms = '{3, 3, 3, 3, 3, 3};
      send_frame(ms, ws, gs, ds, g0, 1);
      ws = '{3, 3, 3, 3, 3, 3}; gs = '{5, 2, 7, 3, 6, 4}; ds = '{7, 7, 7, 7, 7, 7};
      ms = '{1, 1, 1, 1, 1, 1};
      send_frame(ms, ws, gs, ds, g0, 0);
      expect_out("b2b_first", 1008, c1);
      expect_out("b2b_second", 48, c2);
      chk("b2b_spacing", 32'(c2 - c1), 32'd7);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

endmodule

// File: doc/smc_seq_ctrl.md
Name: smc_seq_ctrl

Overview:
Sequential front end for the MOSFET calculator function. It accepts six transistor descriptors serially over a valid/ready handshake and evaluates each one through a single shared device-evaluation unit. It keeps a running sorted top/bottom-3 list and emits one weighted 10-bit result per six-device frame. It replaces the 18-operand parallel interface with a 9-bit serial stream for pin-limited integration.

Parameters:
N_DEV, 6, devices per frame
VAL_W, 7, width of one per-device value (max 84)
OUT_W, 10, result width (max 1008)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  descriptor beat present
in_ready  out  1  block accepts a beat this cycle
mode  in  2  [0]=1 drain current, 0 transconductance; [1]=1 largest three, 0 smallest three; sampled on first beat only
w  in  3  channel width W
v_gs  in  3  gate-source voltage
v_ds  in  3  drain-source voltage
out_valid  out  1  one-cycle result strobe
out_n  out  OUT_W  frame result, zero when out_valid=0

Behaviour:
- Reset is synchronous and active-high: when rst=1 at a clock edge, state goes to IDLE, the beat counter and sort registers clear, and the latched mode clears. out_valid=0, out_n=0, in_ready=1 from the next cycle. rst asserted mid-frame discards the partial frame.
- A beat is accepted when in_valid && in_ready. A beat with in_valid=1 and in_ready=0 is dropped; the source must hold it.
- in_valid gaps inside a frame are legal. The block counts beats, not cycles, and has no timeout.
- FSM:
  - IDLE -> COLLECT on an accepted beat. That beat is device 0 and mode is latched from it.
  - COLLECT -> OUT on the 6th accepted beat.
  - OUT -> IDLE unconditionally after 1 cycle.
  - in_ready=0 only in OUT.
- Latency: out_valid=1 in the cycle immediately after the 6th beat is accepted. Back-to-back frames therefore cost a minimum of 7 cycles each.
- Per-device evaluation, all unsigned and combinational in the sub-module:
  - ov = v_gs-1 when v_gs>=1, else cutoff.
  - Cutoff applies when v_gs<=1: Id=0, gm=0.
  - Triode applies when ov > v_ds: Id = floor(W*(2*ov*v_ds - v_ds^2)/3), gm = floor(2*W*v_ds/3).
  - Saturation applies otherwise (ov <= v_ds): Id = floor(W*ov^2/3), gm = floor(2*W*ov/3).
  - mode[0] selects which value is used.
- Sorting: three registers k0>=k1>=k2 per frame.
  - mode[1]=1: k0..k2 initialise to 0 and each value is inserted if it is greater than k2, keeping the three largest.
  - mode[1]=0: k0..k2 initialise to all-ones and each value is inserted if it is less than k0, keeping the three smallest.
  - Insertion is one compare-shift per accepted beat. Ties keep the earlier device. Tie order does not change the result.
- Result, registered in the OUT cycle:
  - mode[0]=1: out_n = 3*k0 + 4*k1 + 5*k2.
  - mode[0]=0: out_n = k0 + k1 + k2.
  - No overflow is possible (max 1008).
- The frame's first beat inserts into the initialised registers. This includes the beat accepted in IDLE, which sees the init values selected by its own mode.

Decomposition:
- Shared package smc_pkg holds:
  - N_DEV, VAL_W, OUT_W
  - state enum {IDLE, COLLECT, OUT}
  - mode bit indices MODE_ID=0 and MODE_MAX=1
  - weight constants 3/4/5
- Single sub-module smc_dev_eval(w, v_gs, v_ds, sel_id -> val[VAL_W-1:0]), purely combinational. The controller owns the FSM, counter, sort and result logic.

Test Plan:
- Six beats of W=7, VGS=7, VDS=7: mode=2'b11 -> out_n=1008 (Id=84 each); mode=2'b10 -> out_n=84 (gm=28 each).
- W=3, VDS=7, VGS in order {5,2,7,3,6,4} (Id {16,1,36,4,25,9}): mode=2'b11 -> 288; mode=2'b01 -> 48.
- Triode and cutoff mix: one beat W=3, VGS=4, VDS=2 (Id=8, gm=4) plus five beats with VGS=0. mode=2'b11 -> 24; mode=2'b10 -> 4; mode=2'b01 -> 0.
- Protocol:
  - Random in_valid gaps between beats give identical out_n, with out_valid exactly 1 cycle after the 6th beat.
  - in_ready=0 during the OUT cycle; a beat offered there is not counted.
  - mode changes on beats 2-6 are ignored.
- Reset: accept 3 beats, pulse rst for 1 cycle, then send a full frame. The result depends only on the new frame; out_valid/out_n are 0 in the reset cycle and the one after it.
- Back-to-back: two frames with in_valid held high. Frame 2 begins the cycle after OUT; two out_valid pulses occur 7 cycles apart with the correct values.
